// File: rtl/seven_seg_pkg.sv
// Shared types and active-low gfedcba glyph constants for the seven-segment scanner.
// A 0 bit lights a segment; bit 6 is segment g, bit 0 is segment a.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational nibble-to-glyph decoder; output is active-low gfedcba.
// Values 10-15 render as hex letters or as a dash depending on hex_mode.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       blank,
    output seg_t       seg
);

    always_comb begin
        // NOTE: a default on entry keeps every path assigned, so no latch is inferred.
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'h0:    seg = SEG_0;
                4'h1:    seg = SEG_1;
                4'h2:    seg = SEG_2;
                4'h3:    seg = SEG_3;
                4'h4:    seg = SEG_4;
                4'h5:    seg = SEG_5;
                4'h6:    seg = SEG_6;
                4'h7:    seg = SEG_7;
                4'h8:    seg = SEG_8;
                4'h9:    seg = SEG_9;
                4'hA:    seg = hex_mode ? SEG_A : SEG_DASH;
                4'hB:    seg = hex_mode ? SEG_B : SEG_DASH;
                4'hC:    seg = hex_mode ? SEG_C : SEG_DASH;
                4'hD:    seg = hex_mode ? SEG_D : SEG_DASH;
                4'hE:    seg = hex_mode ? SEG_E : SEG_DASH;
                default: seg = hex_mode ? SEG_F : SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for NUM_DIGITS seven-segment digits on a shared bus,
// with leading-zero blanking and pending/display double buffering swapped at frame wrap.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int HEX_MODE   = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] values,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic                    enable,
    output seg_t                    seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam bit INV = (ACTIVE_LOW == 0);
    localparam bit HEX = (HEX_MODE != 0);

    localparam seg_t                  SEG_OFF = INV ? 7'b0000000 : 7'b1111111;
    localparam logic                  DP_OFF  = INV ? 1'b0 : 1'b1;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = INV ? '0 : '1;

    logic [PW-1:0]             prescaler;
    logic [IW-1:0]             idx;
    logic [4*NUM_DIGITS-1:0]   pending;
    logic [4*NUM_DIGITS-1:0]   display;
    logic [NUM_DIGITS-1:0]     pend_dp;
    logic [NUM_DIGITS-1:0]     disp_dp;
    logic                      pend_v;
    logic [NUM_DIGITS-1:0]     lz_mask;
    logic                      nonzero_above;
    logic                      terminal;
    logic                      advance;
    logic                      wrap;
    seg_t                      glyph;
    logic [NUM_DIGITS-1:0]     onehot;

    assign terminal = (prescaler == PW'(SCAN_DIV - 1));
    assign advance  = enable && terminal;
    assign wrap     = advance && (idx == IW'(NUM_DIGITS - 1));
    assign onehot   = NUM_DIGITS'(1) << idx;

    // Digit k (k>0) is blank when it and every more significant digit are zero.
    always_comb begin
        lz_mask       = '0;
        nonzero_above = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nonzero_above = nonzero_above || (display[4*k +: 4] != 4'h0);
            lz_mask[k]    = blank_lz && (k != 0) && !nonzero_above;
        end
    end

    seven_seg_decode u_decode (
        .nibble   (display[4*idx +: 4]),
        .hex_mode (HEX),
        .blank    (lz_mask[idx]),
        .seg      (glyph)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (enable) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            prescaler <= terminal ? '0 : prescaler + 1'b1;
            if (terminal)
                idx <= wrap ? '0 : idx + 1'b1;
        end
    end

    // A load on the wrap cycle bypasses pending so it lands in the frame that starts now.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the buffers are reset too, since reset must discard pending data and show 0.
            pending <= '0;
            pend_dp <= '0;
            display <= '0;
            disp_dp <= '0;
            pend_v  <= 1'b0;
        end else if (load && wrap) begin
            display <= values;
            disp_dp <= dp_in;
            pend_v  <= 1'b0;
        end else if (load) begin
            pending <= values;
            pend_dp <= dp_in;
            pend_v  <= 1'b1;
        end else if (wrap && pend_v) begin
            display <= pending;
            disp_dp <= pend_dp;
            pend_v  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (enable) begin
                seg <= INV ? ~glyph : glyph;
                dp  <= INV ? disp_dp[idx] : ~disp_dp[idx];
                an  <= INV ? onehot : ~onehot;
            end else begin
                seg <= SEG_OFF;
                dp  <= DP_OFF;
                an  <= AN_OFF;
            end
        end
    end

endmodule
